// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam arb_state_t ARB_IDLE  = IDLE;
  localparam arb_state_t ARB_BURST = BURST;

  // Beat counter width: enough to hold MAX_BURST-1, never narrower than one bit.
  function automatic int cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester bundle plus FIFO write port as seen by the write-side arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  import fifo_wr_arb_pkg::*;

  localparam int GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [GID_W-1:0]              grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_last, req_data, full,
    output req_ready, wr_en, wr_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_last, req_data, full,
    input  req_ready, wr_en, wr_data, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_pick.sv
// Round-robin pick: first set request strictly after last_gnt, wrapping around.
module rr_priority_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   last_gnt,
  output logic               found,
  output logic [GID_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] mask;
  logic [2*NUM_REQ-1:0] masked;

  // Lower copy is masked up to last_gnt; the upper copy supplies the wrap-around.
  assign dbl = {req, req};

  generate
    for (genvar gi = 0; gi < 2*NUM_REQ; gi++) begin : g_mask
      assign mask[gi] = (gi > int'(last_gnt));
    end
  endgenerate

  assign masked = dbl & mask;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (masked[i]) begin
        found = 1'b1;
        idx   = GID_W'(i % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port among NUM_REQ requesters: round-robin grants held
// for a packet (or MAX_BURST beats), every beat gated by the FIFO full flag.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst_n,
  fifo_wr_arbiter_if.master    bus
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int BW    = cnt_width(MAX_BURST);

  arb_state_t            state_q, state_d;
  logic [GID_W-1:0]      grant_q, grant_d;
  logic [GID_W-1:0]      last_gnt_q, last_gnt_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  pick_found;
  logic [GID_W-1:0]      pick_idx;
  logic                  beat_fire;
  logic                  grant_end;
  logic [NUM_REQ-1:0]    ready;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .GID_W   (GID_W)
  ) u_pick (
    .req      (bus.req_valid),
    .last_gnt (last_gnt_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data
      assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // last_gnt resets to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      last_gnt_q <= GID_W'(NUM_REQ-1);
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_gnt_q <= last_gnt_d;
      beat_q     <= beat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_gnt_d = last_gnt_q;
    beat_d     = beat_q;
    ready      = '0;
    beat_fire  = 1'b0;
    grant_end  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          beat_d  = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        ready[grant_q] = !bus.full;
        beat_fire      = bus.req_valid[grant_q] && !bus.full;
        // Packet end and burst cap on the same beat still end the grant once.
        grant_end      = bus.req_last[grant_q] || (beat_q == BW'(MAX_BURST-1));
        if (beat_fire) begin
          if (grant_end) begin
            state_d    = ARB_IDLE;
            last_gnt_d = grant_q;
            beat_d     = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.wr_en     = beat_fire;
  assign bus.wr_data   = data_arr[grant_q];
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q == ARB_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench: per-requester packet sources, a grant-level round-robin model
// feeding an expected-write queue, and a monitor that checks every FIFO write.
module tb_fifo_wr_arbiter;
  import fifo_wr_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int GW = $clog2(N);

  typedef struct packed {
    logic [GW-1:0] id;
    logic [DW-1:0] d;
  } exp_t;

  logic wr_clk   = 1'b0;
  logic wr_rst_n = 1'b0;
  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk   (wr_clk),
    .wr_rst_n (wr_rst_n),
    .bus      (bus)
  );

  logic [DW-1:0] src_d [N][$];
  bit            src_l [N][$];
  logic [DW-1:0] mdl_d [N][$];
  bit            mdl_l [N][$];
  exp_t          exp_q [$];

  int checks = 0;
  int errors = 0;
  int model_last = N-1;
  int gap_pct = 0, gap_len = 0, full_pct = 0, full_hold = 0;
  int gap_left [N];
  int wr_seen = 0;
  logic [N-1:0] fire;
  bit            prev_wr;
  logic [GW-1:0] prev_id;

  task automatic add_packet(input int id, input int len);
    for (int k = 0; k < len; k++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      src_d[id].push_back(d);
      src_l[id].push_back(k == len-1);
      mdl_d[id].push_back(d);
      mdl_l[id].push_back(k == len-1);
    end
  endtask

  // Grant-level model: next non-empty source after the previous owner, then up
  // to MB words or through the end of its packet.
  task automatic model_run();
    bit done = 0;
    while (!done) begin
      int owner = -1;
      for (int s = 1; s <= N; s++) begin
        int c = (model_last + s) % N;
        if (owner < 0 && mdl_d[c].size() > 0) owner = c;
      end
      if (owner < 0) begin
        done = 1;
      end else begin
        bit stop = 0;
        for (int b = 0; b < MB && !stop; b++) begin
          exp_t e;
          bit   l;
          e.id = GW'(owner);
          e.d  = mdl_d[owner].pop_front();
          l    = mdl_l[owner].pop_front();
          exp_q.push_back(e);
          if (l || mdl_d[owner].size() == 0) stop = 1;
        end
        model_last = owner;
      end
    end
  endtask

  task automatic flush_all();
    for (int i = 0; i < N; i++) begin
      src_d[i].delete(); src_l[i].delete();
      mdl_d[i].delete(); mdl_l[i].delete();
    end
    exp_q.delete();
    model_last = N-1;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      @(negedge wr_clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge wr_clk);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Source driver: retire transferred beats, present queue heads, random full.
  initial begin
    logic [DW-1:0] dd;
    bit            dl;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.full      = 1'b0;
    fire          = '0;
    for (int i = 0; i < N; i++) gap_left[i] = 0;
    forever begin
      @(negedge wr_clk);
      for (int i = 0; i < N; i++) begin
        if (fire[i] && src_d[i].size() > 0) begin
          dd = src_d[i].pop_front();
          dl = src_l[i].pop_front();
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.busy && int'(bus.grant_id) == i) begin
          if (gap_left[i] > 0) gap_left[i]--;
          else if (gap_pct > 0 && src_d[i].size() > 0 && int'($urandom_range(0, 99)) < gap_pct)
            gap_left[i] = (gap_len > 0) ? gap_len : int'($urandom_range(1, 5));
        end else begin
          gap_left[i] = 0;
        end
        bus.req_valid[i]        = (src_d[i].size() > 0) && (gap_left[i] == 0);
        bus.req_last[i]         = bus.req_valid[i] ? src_l[i][0] : 1'b0;
        bus.req_data[i*DW +: DW] = (src_d[i].size() > 0) ? src_d[i][0] : DW'($urandom);
      end
      if (full_hold > 0) begin
        bus.full = 1'b1;
        full_hold--;
      end else begin
        bus.full = (full_pct > 0) && (int'($urandom_range(0, 99)) < full_pct);
      end
      #1;
      fire = bus.req_valid & bus.req_ready;
    end
  end

  // Monitor: one line per FIFO write, rule checks every cycle out of reset.
  initial begin
    exp_t e;
    logic exp_wr;
    prev_wr = 1'b0;
    prev_id = '0;
    forever begin
      @(negedge wr_clk);
      #2;
      if (!wr_rst_n) begin
        prev_wr = 1'b0;
      end else begin
        checks++;
        if (!$onehot0(bus.req_ready)) begin
          errors++;
          $display("FAIL ready_onehot actual=%b required=one-hot-or-zero", bus.req_ready);
        end
        if (bus.busy) begin
          checks++;
          if ((bus.req_ready & ~(N'(1) << bus.grant_id)) != '0) begin
            errors++;
            $display("FAIL ready_owner ready=%b grant=%0d", bus.req_ready, bus.grant_id);
          end
          exp_wr = bus.req_valid[bus.grant_id] && !bus.full;
          check_bit("wr_en_rule", bus.wr_en, exp_wr);
        end else begin
          checks++;
          if (bus.wr_en !== 1'b0 || bus.req_ready !== '0) begin
            errors++;
            $display("FAIL idle_quiet wr_en=%b ready=%b required=0/0", bus.wr_en, bus.req_ready);
          end
        end
        if (bus.full) begin
          checks++;
          if (bus.wr_en !== 1'b0 || bus.req_ready !== '0) begin
            errors++;
            $display("FAIL full_gate wr_en=%b ready=%b required=0/0", bus.wr_en, bus.req_ready);
          end
        end
        if (bus.wr_en === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write id=%0d data=%h required=none", bus.grant_id, bus.wr_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.grant_id !== e.id || bus.wr_data !== e.d) begin
              errors++;
              $display("FAIL write id=%0d data=%h required id=%0d data=%h",
                       bus.grant_id, bus.wr_data, e.id, e.d);
            end else begin
              $display("write id=%0d data=%h ok", bus.grant_id, bus.wr_data);
            end
          end
          wr_seen++;
          checks++;
          if (prev_wr && prev_id != bus.grant_id) begin
            errors++;
            $display("FAIL bubble prev=%0d now=%0d required idle cycle between", prev_id, bus.grant_id);
          end
          prev_id = bus.grant_id;
        end
        prev_wr = bus.wr_en;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cyc;
    // Reset with every requester valid: outputs quiet, requester 0 first after release.
    wr_rst_n = 1'b0;
    for (int i = 0; i < N; i++) add_packet(i, 1);
    model_run();
    repeat (3) @(negedge wr_clk);
    #2;
    check_bit("rst_wr_en", bus.wr_en, 1'b0);
    check_bit("rst_ready_any", |bus.req_ready, 1'b0);
    check_bit("rst_busy", bus.busy, 1'b0);
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    @(negedge wr_clk);
    #2;
    check_bit("first_busy", bus.busy, 1'b1);
    check_bit("first_wr_en", bus.wr_en, 1'b1);
    check_bit("first_gid0", bus.grant_id == '0, 1'b1);
    drain("reset");

    // Round-robin with single-beat packets.
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) add_packet(i, 1);
    model_run();
    drain("rr");

    // Burst cap: a 10-beat packet on requester 2 interleaved with requester 1.
    add_packet(2, 10);
    for (int r = 0; r < 3; r++) add_packet(1, 1);
    model_run();
    drain("burst_cap");

    // Full held three cycles mid-burst.
    add_packet(1, 6);
    add_packet(3, 3);
    model_run();
    repeat (3) @(posedge wr_clk);
    full_hold = 3;
    drain("full_hold");

    // Owner valid gaps of five cycles while others request.
    gap_len = 5;
    gap_pct = 60;
    add_packet(0, 6); add_packet(1, 4); add_packet(2, 5); add_packet(3, 3);
    model_run();
    drain("valid_gap");
    gap_pct = 0;
    gap_len = 0;

    // Reset on the second beat of a burst.
    add_packet(0, 4);
    add_packet(2, 3);
    model_run();
    base = wr_seen;
    cyc  = 0;
    while (wr_seen < base + 2 && cyc < 200) begin
      @(negedge wr_clk);
      #3;
      cyc++;
    end
    check_bit("second_beat_seen", wr_seen >= base + 2, 1'b1);
    wr_rst_n = 1'b0;
    flush_all();
    #1;
    check_bit("midrst_wr_en", bus.wr_en, 1'b0);
    check_bit("midrst_busy", bus.busy, 1'b0);
    check_bit("midrst_ready_any", |bus.req_ready, 1'b0);
    add_packet(1, 1); add_packet(0, 2); add_packet(3, 1);
    model_run();
    repeat (2) @(negedge wr_clk);
    wr_rst_n = 1'b1;
    @(negedge wr_clk);
    #2;
    check_bit("restart_gid0", bus.busy && bus.grant_id == '0, 1'b1);
    drain("reset_mid");

    // Random mix of packets, full and gaps.
    for (int r = 0; r < 8; r++) begin
      full_pct = int'($urandom_range(0, 30));
      gap_pct  = int'($urandom_range(0, 30));
      for (int i = 0; i < N; i++) begin
        int np = int'($urandom_range(0, 2));
        for (int p = 0; p < np; p++) add_packet(i, int'($urandom_range(1, 7)));
      end
      model_run();
      drain("random");
    end
    full_pct = 0;
    gap_pct  = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side scheduler for the asynchronous FIFO. It shares the single FIFO write port among `NUM_REQ` requesters in the `wr_clk` domain, using round-robin arbitration with burst/packet hold. It gates every write with the FIFO `full` flag, so no requester can overflow the FIFO. It sits directly in front of the FIFO write pointer/memory and drives its `wr_en` and write data.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: FIFO word width.
- `MAX_BURST`, 4: maximum beats per grant, 1..256.
- `GID_W`, `$clog2(NUM_REQ)`: width of the grant index (derived).

Ports:
- `wr_clk`  in  1  write-domain clock.
- `wr_rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  per-requester data valid.
- `req_last`  in  `NUM_REQ`  per-requester last beat of packet, qualified by valid.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  packed data; requester i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready`  out  `NUM_REQ`  per-requester accept; a beat transfers when valid && ready.
- `full`  in  1  FIFO full flag (write domain).
- `wr_en`  out  1  FIFO write strobe.
- `wr_data`  out  `DATA_WIDTH`  FIFO write data.
- `grant_id`  out  `GID_W`  index of the current owner.
- `busy`  out  1  high while in BURST.

## Operation
- FSM has two states, in package enum `arb_state_t`:
  - **IDLE**
    - If any `req_valid` is set, select the first set bit searching from `(last_gnt+1) mod NUM_REQ` upward with wrap.
    - Register that index as `grant_id`, clear `beat_cnt`, and go to BURST.
    - If no `req_valid` is set, stay in IDLE.
  - **BURST**
    - Only `grant_id` is served.
    - `req_ready[grant_id] = !full`; all other `req_ready` bits are 0.
    - `wr_en = req_valid[grant_id] && !full`.
    - `wr_data = req_data[grant_id]`, driven combinationally.
    - Each beat increments `beat_cnt`.
    - The grant ends on a beat with `req_last[grant_id]=1` or `beat_cnt==MAX_BURST-1`. The FSM then goes to IDLE with `last_gnt <= grant_id`.
    - If the owner drops `req_valid` mid-packet, the grant is held; no timeout.
- Fairness:
  - Every requester with valid asserted is granted within `NUM_REQ-1` grants.
  - `last_gnt` updates only at grant end.
- Full:
  - `full=1` forces `wr_en=0` and `req_ready=0` the same cycle.
  - The beat and `beat_cnt` stall; state and grant are unchanged.
- `wr_en` is never asserted in IDLE.
- `req_ready` is one-hot or zero at all times.

## Timing
- Reset values:
  - state IDLE.
  - `grant_id=0`, `last_gnt=NUM_REQ-1`, so requester 0 wins first.
  - `beat_cnt=0`.
  - `busy=0`, `wr_en=0`, `req_ready=0`.
  - `wr_data` = `req_data` slice 0 (don't-care while `wr_en=0`).
- Arbitration latency:
  - A request seen in IDLE at edge N makes BURST active after edge N.
  - The first beat can transfer in cycle N+1.
- Each grant costs one IDLE bubble cycle before the next arbitration.
- Data path:
  - `wr_en` and `wr_data` are combinational from the registered `grant_id` and the inputs; there is no pipeline stage.
  - The FIFO samples them on the next `wr_clk` edge.
- `req_last` and the `MAX_BURST` limit in the same beat give a single grant end; no double count.
- `MAX_BURST=1`: every grant is exactly one beat.
- Reset asserted mid-burst:
  - All outputs drop to reset values asynchronously.
  - The partial packet is abandoned; requesters must restart.
- `beat_cnt` width is `$clog2(MAX_BURST)`, minimum 1. It wraps never, because the grant ends at `MAX_BURST-1`.

## Structure
- Package `fifo_wr_arb_pkg`:
  - `arb_state_t` (IDLE, BURST).
  - Constants `ARB_IDLE` and `ARB_BURST`.
- Sub-module `rr_priority_pick`: purely combinational.
  - Inputs: request vector and `last_gnt`.
  - Outputs: `found` and the index.
  - Implemented as a double-width masked priority encoder.
- The FSM, `beat_cnt` and output muxing live in `fifo_wr_arbiter`.

## Test plan
- **Reset:** hold `wr_rst_n=0` with all `req_valid=1`. Require `wr_en=0`, `req_ready=0`, `busy=0`. Release; require requester 0 granted and its first beat written in the 2nd cycle after release.
- **Round-robin:**
  - Setup: `NUM_REQ=4`, all valid, 1-beat packets (`req_last=1`).
  - Required write order: 0,1,2,3,0,1; one bubble between each.
  - The data word written must equal the owner's `req_data`.
- **Burst cap:** `MAX_BURST=4`, requester 2 streams 10 beats with `req_last=0`, requester 1 valid. Require grants 2(4 beats), 1, 2(4), 1, 2(2).
- **Full backpressure:**
  - Setup: assert `full` for 3 cycles mid-burst.
  - Require `wr_en=0` and `req_ready=0` during those cycles and `beat_cnt` frozen.
  - After `full` drops, the burst resumes with no beat lost or duplicated.
- **Valid gap:** the owner deasserts valid for 5 cycles mid-packet while others request. Require the grant held, `wr_en=0`, and no other `req_ready` asserted.
- **Reset mid-burst:** assert `wr_rst_n` low on the 2nd beat. Require immediate `wr_en=0`; after release, arbitration restarts from requester 0.
